// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage holding the PC, driving the instruction memory
// address and buffering fetched {pc, instr} pairs in a small prefetch FIFO
// that decode drains through a valid/ready handshake. A redirect loads a new
// PC and discards everything buffered.
module fetch_queue #(
  parameter int unsigned       N        = 64,
  parameter int unsigned       IW       = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [N-1:0]      RESET_PC = '0,
  parameter int unsigned       PC_INC   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCSrc_F,
  input  logic [N-1:0]               PCBranch_F,
  output logic [N-1:0]               imem_addr_F,
  input  logic [IW-1:0]              imem_data_F,
  output logic [IW-1:0]              instr_D,
  output logic [N-1:0]               pc_D,
  output logic                       valid_D,
  input  logic                       ready_D,
  output logic [$clog2(DEPTH):0]     count_F
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [N-1:0]  C_INC   = N'(PC_INC);

  logic [N-1:0]  r_pc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_mem_pc    [DEPTH];
  logic [IW-1:0] r_mem_instr [DEPTH];

  logic          w_deq;
  logic          w_space;
  logic          w_enq;
  logic [CW-1:0] w_count_nxt;

  // Handshake and occupancy bookkeeping; the redirect clears the count
  // regardless of any same-cycle enqueue or dequeue.
  always_comb begin
    w_deq       = valid_D & ready_D;
    w_space     = (r_count < C_DEPTH) | w_deq;
    w_enq       = w_space & ~PCSrc_F;
    w_count_nxt = r_count;
    if (PCSrc_F) begin
      w_count_nxt = '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // PC register, pointers and occupancy; PC only advances when the fetched
  // word actually lands in the FIFO, so a stalled fetch re-presents the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (PCSrc_F) begin
        r_pc   <= PCBranch_F;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_enq) begin
          r_pc   <= r_pc + C_INC;
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_deq) begin
          r_rptr <= r_rptr + AW'(1);
        end
      end
    end
  end

  // FIFO storage is not reset; valid_D gates every read of it.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_pc[r_wptr]    <= r_pc;
      r_mem_instr[r_wptr] <= imem_data_F;
    end
  end

  assign imem_addr_F = r_pc;
  assign valid_D     = (r_count != '0);
  assign count_F     = r_count;
  assign pc_D        = r_mem_pc[r_rptr];
  assign instr_D     = r_mem_instr[r_rptr];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed-vector bench for fetch_queue with default
// parameters (N=64, IW=32, DEPTH=4, RESET_PC=0, PC_INC=4).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        PCSrc_F;
  logic [63:0] PCBranch_F;
  logic [63:0] imem_addr_F;
  logic [31:0] imem_data_F;
  logic [31:0] instr_D;
  logic [63:0] pc_D;
  logic        valid_D;
  logic        ready_D;
  logic [2:0]  count_F;

  int total = 0;
  int bad   = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
    .imem_addr_F(imem_addr_F), .imem_data_F(imem_data_F), .instr_D(instr_D),
    .pc_D(pc_D), .valid_D(valid_D), .ready_D(ready_D), .count_F(count_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word encodes its own address.
  assign imem_data_F = 32'hE000_0000 | imem_addr_F[31:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    reset      = 1'b1;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;
    ready_D    = rdy;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    reset = 1'b1;
    #1;
    total++;
    if (count_F !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_F); end
    total++;
    if (valid_D !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_D); end
    total++;
    if (imem_addr_F !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr_F); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      exp_pc = 64'(k * 4);
      total++;
      if (valid_D !== 1'b1 || pc_D !== exp_pc || instr_D !== (32'hE000_0000 | exp_pc[31:0])) begin
        bad++;
        $display("FAIL stream_head k=%0d valid=%0b pc=%h instr=%h exp_pc=%h", k, valid_D, pc_D, instr_D, exp_pc);
      end
      total++;
      if (count_F !== 3'd1 || imem_addr_F !== exp_pc + 64'd4) begin
        bad++;
        $display("FAIL stream_cnt k=%0d count=%0d addr=%h exp_count=1 exp_addr=%h", k, count_F, imem_addr_F, exp_pc + 64'd4);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [63:0] exp_pc;
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (count_F !== 3'((k > 4) ? 4 : k)) begin
        bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count_F, (k > 4) ? 4 : k);
      end
    end
    total++;
    if (imem_addr_F !== 64'h10) begin bad++; $display("FAIL fill_addr got=%h exp=10", imem_addr_F); end
    ready_D = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_pc = 64'(k * 4);
      total++;
      if (valid_D !== 1'b1 || pc_D !== exp_pc || instr_D !== (32'hE000_0000 | exp_pc[31:0])) begin
        bad++;
        $display("FAIL drain_head k=%0d valid=%0b pc=%h instr=%h exp_pc=%h", k, valid_D, pc_D, instr_D, exp_pc);
      end
      step();
    end
  endtask

  task automatic test_full_enq_deq();
    do_reset(1'b0);
    repeat (5) step();
    ready_D = 1'b1;
    step();
    ready_D = 1'b0;
    total++;
    if (count_F !== 3'd4) begin bad++; $display("FAIL full_swap_count got=%0d exp=4", count_F); end
    total++;
    if (imem_addr_F !== 64'h14) begin bad++; $display("FAIL full_swap_addr got=%h exp=14", imem_addr_F); end
    total++;
    if (pc_D !== 64'h4) begin bad++; $display("FAIL full_swap_head got=%h exp=4", pc_D); end
    step();
    total++;
    if (count_F !== 3'd4 || imem_addr_F !== 64'h14) begin
      bad++; $display("FAIL full_hold count=%0d addr=%h exp_count=4 exp_addr=14", count_F, imem_addr_F);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) step();
    total++;
    if (count_F !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", count_F); end
    ready_D    = 1'b1;
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h400;
    step();
    PCSrc_F = 1'b0;
    total++;
    if (count_F !== 3'd0 || valid_D !== 1'b0 || imem_addr_F !== 64'h400) begin
      bad++; $display("FAIL redir_flush count=%0d valid=%0b addr=%h exp 0/0/400", count_F, valid_D, imem_addr_F);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (valid_D !== 1'b1 || pc_D !== 64'h400 + 64'(k * 4)) begin
        bad++; $display("FAIL redir_head k=%0d valid=%0b pc=%h exp=%h", k, valid_D, pc_D, 64'h400 + 64'(k * 4));
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h30;
    step();
    PCSrc_F = 1'b0;
    repeat (4) step();
    total++;
    if (count_F !== 3'd4 || imem_addr_F !== 64'h40) begin
      bad++; $display("FAIL areset_pre count=%0d addr=%h exp 4/40", count_F, imem_addr_F);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (count_F !== 3'd0 || valid_D !== 1'b0 || imem_addr_F !== 64'h0) begin
      bad++; $display("FAIL areset_now count=%0d valid=%0b addr=%h exp 0/0/0", count_F, valid_D, imem_addr_F);
    end
    step();
    reset   = 1'b0;
    ready_D = 1'b1;
    step();
    total++;
    if (valid_D !== 1'b1 || pc_D !== 64'h0 || imem_addr_F !== 64'h4) begin
      bad++; $display("FAIL areset_restart valid=%0b pc=%h addr=%h exp 1/0/4", valid_D, pc_D, imem_addr_F);
    end
  endtask

  task automatic test_pc_wrap();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_pc[1] = 64'h0;
    exp_pc[2] = 64'h4;
    do_reset(1'b1);
    step();
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    PCSrc_F = 1'b0;
    total++;
    if (imem_addr_F !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      bad++; $display("FAIL wrap_addr got=%h exp=fffffffffffffffc", imem_addr_F);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (valid_D !== 1'b1 || pc_D !== exp_pc[k]) begin
        bad++; $display("FAIL wrap_head k=%0d valid=%0b pc=%h exp=%h", k, valid_D, pc_D, exp_pc[k]);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;
    ready_D    = 1'b0;
    test_reset();
    test_stream();
    test_fill_drain();
    test_full_enq_deq();
    test_redirect();
    test_async_reset();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
